// File: rtl/detector_transicao_debounce.sv
// Multi-channel pushbutton front end: synchroniser, stable-time debounce and
// registered edge pulses, with optional auto-repeat while a button is held.
module detector_transicao_debounce #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                enable,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] edge_detected
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DEB_LIM = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DLY_LIM = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PER_LIM = CW'(REPEAT_PERIOD);
    localparam logic          ACTIVE  = (EDGE_MODE == 1) ? 1'b0 : 1'b1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          deb_q;
        logic [CW-1:0]          deb_d;
        logic                   lvl_q;
        logic                   lvl_d;
        logic                   pulse_q;
        logic                   pulse_d;
        logic                   s;
        logic                   changed;
        logic                   edge_ok;
        logic                   rpt_fire;

        assign s = sync_q[SYNC_STAGES-1];

        // Debounce: the synced level must differ for a full counter run before it is accepted
        always_comb begin
            deb_d = '0;
            lvl_d = lvl_q;
            if (s != lvl_q) begin
                if (deb_q >= DEB_LIM) begin
                    lvl_d = s;
                    deb_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end else begin
                deb_d = '0;
            end
        end

        // Edge qualification against the selected edge type
        always_comb begin
            changed = (lvl_d != lvl_q);
            edge_ok = 1'b0;
            case (EDGE_MODE)
                0:       edge_ok = changed & lvl_d;
                1:       edge_ok = changed & ~lvl_d;
                default: edge_ok = changed;
            endcase
            pulse_d = enable & (edge_ok | rpt_fire);
        end

        if (REPEAT_EN != 0) begin : g_rpt
            logic [CW-1:0] rpt_q;
            logic [CW-1:0] rpt_d;
            logic          ph_q;
            logic          ph_d;
            logic          en_q;
            logic [CW-1:0] limit;

            assign limit = ph_q ? PER_LIM : DLY_LIM;

            // Repeat timer: counts only while the active level is held and enable was already high,
            // so entering the level or re-enabling restarts timing from that edge
            always_comb begin
                rpt_d    = '0;
                ph_d     = 1'b0;
                rpt_fire = 1'b0;
                if (!changed && (lvl_q == ACTIVE) && enable && en_q) begin
                    if ((rpt_q + 1'b1) == limit) begin
                        rpt_fire = 1'b1;
                        rpt_d    = '0;
                        ph_d     = 1'b1;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                        ph_d  = ph_q;
                    end
                end else begin
                    rpt_d = '0;
                    ph_d  = 1'b0;
                end
            end

            // Repeat state registers
            always_ff @(posedge clock or posedge clear) begin
                if (clear) begin
                    rpt_q <= '0;
                    ph_q  <= 1'b0;
                    en_q  <= 1'b0;
                end else begin
                    rpt_q <= rpt_d;
                    ph_q  <= ph_d;
                    en_q  <= enable;
                end
            end
        end else begin : g_norpt
            assign rpt_fire = 1'b0;
        end

        // Channel state registers
        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                sync_q  <= '0;
                deb_q   <= '0;
                lvl_q   <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], signal_in[g]};
                deb_q   <= deb_d;
                lvl_q   <= lvl_d;
                pulse_q <= pulse_d;
            end
        end

        assign level_out[g]     = lvl_q;
        assign edge_detected[g] = pulse_q;
    end

endmodule

// File: tb/tb_detector_transicao_debounce.sv
// Directed bench: four parameterisations share one stimulus and are checked
// edge by edge against hand-computed pulse positions.
module tb_detector_transicao_debounce;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] sig = 2'b00;

    logic [1:0] lv_r0, ed_r0, lv_r1, ed_r1, lv_b, ed_b, lv_f, ed_f;
    logic [1:0] e_lv, e_r0, e_r1, e_b, e_f;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    detector_transicao_debounce #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_r0 (
        .clock(clock), .clear(clear), .enable(enable), .signal_in(sig),
        .level_out(lv_r0), .edge_detected(ed_r0));

    detector_transicao_debounce #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_r1 (
        .clock(clock), .clear(clear), .enable(enable), .signal_in(sig),
        .level_out(lv_r1), .edge_detected(ed_r1));

    detector_transicao_debounce #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_b (
        .clock(clock), .clear(clear), .enable(enable), .signal_in(sig),
        .level_out(lv_b), .edge_detected(ed_b));

    detector_transicao_debounce #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) u_f (
        .clock(clock), .clear(clear), .enable(enable), .signal_in(sig),
        .level_out(lv_f), .edge_detected(ed_f));

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tn, input int k, input logic [1:0] lv,
                             input logic [1:0] r0, input logic [1:0] r1,
                             input logic [1:0] b, input logic [1:0] f);
        check($sformatf("%s[%0d] level_r0", tn, k), lv_r0, lv);
        check($sformatf("%s[%0d] level_r1", tn, k), lv_r1, lv);
        check($sformatf("%s[%0d] level_both", tn, k), lv_b, lv);
        check($sformatf("%s[%0d] level_fall", tn, k), lv_f, lv);
        check($sformatf("%s[%0d] edge_r0", tn, k), ed_r0, r0);
        check($sformatf("%s[%0d] edge_r1", tn, k), ed_r1, r1);
        check($sformatf("%s[%0d] edge_both", tn, k), ed_b, b);
        check($sformatf("%s[%0d] edge_fall", tn, k), ed_f, f);
    endtask

    initial begin
        // reset state
        step();
        step();
        check_all("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        clear = 1'b0;

        // clean press on ch0 sampled at edge 0, held through edge 40
        sig = 2'b01;
        for (int k = 0; k < 60; k++) begin
            step();
            e_lv = {1'b0, (k >= 6 && k < 47)};
            e_r0 = {1'b0, (k == 6)};
            e_b  = {1'b0, (k == 6 || k == 47)};
            e_f  = {1'b0, (k == 47)};
            e_r1 = {1'b0, (k == 6 || (k >= 16 && k <= 46 && (k - 16) % 3 == 0))};
            check_all("press", k, e_lv, e_r0, e_r1, e_b, e_f);
            sig[0] = (k + 1 <= 40);
        end

        // ch0 bounces, ch1 clean; both released at edge 21
        sig = 2'b11;
        for (int k = 0; k < 36; k++) begin
            step();
            e_lv = {(k >= 6 && k < 27), (k >= 10 && k < 27)};
            e_r0 = {(k == 6), (k == 10)};
            e_b  = {(k == 6 || k == 27), (k == 10 || k == 27)};
            e_f  = {(k == 27), (k == 27)};
            e_r1 = {(k == 6 || k == 16 || k == 19 || k == 22 || k == 25),
                    (k == 10 || k == 20 || k == 23 || k == 26)};
            check_all("bounce", k, e_lv, e_r0, e_r1, e_b, e_f);
            sig[0] = ((k + 1 <= 2) || (k + 1 >= 4 && k + 1 <= 20));
            sig[1] = (k + 1 <= 20);
        end

        // press with enable low, enable first sampled high at edge 12
        sig    = 2'b01;
        enable = 1'b0;
        for (int k = 0; k < 46; k++) begin
            step();
            e_lv = {1'b0, (k >= 6 && k < 36)};
            e_r0 = 2'b00;
            e_b  = {1'b0, (k == 36)};
            e_f  = {1'b0, (k == 36)};
            e_r1 = {1'b0, (k == 22 || k == 25 || k == 28 || k == 31 || k == 34)};
            check_all("enable", k, e_lv, e_r0, e_r1, e_b, e_f);
            enable = (k + 1 >= 12);
            sig[0] = (k + 1 <= 29);
        end

        // clear mid-debounce (after edge 3) and mid-repeat (after edge 21), input held high
        sig = 2'b01;
        for (int k = 0; k < 45; k++) begin
            step();
            if (k <= 4 || k == 22) begin
                e_lv = 2'b00; e_r0 = 2'b00; e_r1 = 2'b00; e_b = 2'b00;
            end else if (k <= 21) begin
                e_lv = {1'b0, (k >= 11)};
                e_r0 = {1'b0, (k == 11)};
                e_b  = e_r0;
                e_r1 = {1'b0, (k == 11 || k == 21)};
            end else begin
                e_lv = {1'b0, (k >= 29)};
                e_r0 = {1'b0, (k == 29)};
                e_b  = e_r0;
                e_r1 = {1'b0, (k == 29 || k == 39 || k == 42)};
            end
            check_all("clear", k, e_lv, e_r0, e_r1, e_b, 2'b00);
            if (k == 3 || k == 21) begin
                #1 clear = 1'b1;
                #1;
                check_all("async_clr", k, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
            end
            if (k == 4 || k == 22) clear = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
